cgra_tcdm_bridge: RTL and testbench

CGRA_TCDM_BRIDGE -- requirements
Module: cgra_tcdm_bridge

---
 rtl/cgra_bridge_pkg.sv | 30 +++
 rtl/cgra_bridge_rsp_fifo.sv | 55 +++++
 rtl/cgra_tcdm_bridge.sv | 198 +++++++++++++++++++
 tb/tb_cgra_tcdm_bridge.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cgra_bridge_pkg.sv
// -----------------------------------------------------------------------------
// cgra_bridge_pkg
// Shared types and helpers for the CGRA <-> TCDM bridge.
//   cgra_data_t : CGRA channel message layout {payload, predicate, bypass}.
//                 The payload is the MSB field, the predicate is bit 1 and
//                 bypass is bit 0.
//   prio_e      : per-port arbitration priority (write-first / read-first)
//   addr_shift  : byte shift that turns a CGRA word index into a TCDM byte
//                 offset for a given TCDM data width
// -----------------------------------------------------------------------------
package cgra_bridge_pkg;

  localparam int unsigned CGRA_PAYLOAD_W = 16;

  typedef struct packed {
    logic [CGRA_PAYLOAD_W-1:0] payload;
    logic                      predicate;
    logic                      bypass;
  } cgra_data_t;

  typedef enum logic {
    PRIO_WRITE = 1'b0,
    PRIO_READ  = 1'b1
  } prio_e;

  function automatic int unsigned addr_shift(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/cgra_bridge_rsp_fifo.sv
// -----------------------------------------------------------------------------
// cgra_bridge_rsp_fifo
// Per-port read-response buffer. First-word-fall-through, power-of-2 depth.
// Push and pop may occur in the same cycle, including when full: the head
// slot is read combinationally before the edge that overwrites it.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset (pointers only)
//   push_i/data_i: enqueue one entry
//   pop_i        : dequeue the head entry (caller guarantees non-empty)
//   data_o       : head entry
//   empty_o      : no entries stored
//   count_o      : number of stored entries (0..Depth)
// -----------------------------------------------------------------------------
module cgra_bridge_rsp_fifo
  import cgra_bridge_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         data_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         data_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned AW = $clog2(Depth);

  logic [Width-1:0] r_mem [Depth];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (push_i) r_wptr <= r_wptr + (AW+1)'(1);
      if (pop_i)  r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push_i) r_mem[r_wptr[AW-1:0]] <= data_i;
  end

  assign data_o  = r_mem[r_rptr[AW-1:0]];
  assign count_o = r_wptr - r_rptr;
  assign empty_o = (r_wptr == r_rptr);

endmodule

// File: rtl/cgra_tcdm_bridge.sv
// -----------------------------------------------------------------------------
// cgra_tcdm_bridge
// Bridges NumPorts CGRA data-memory channels onto NumPorts independent TCDM
// ports. Each port arbitrates its own write and read request, translates the
// CGRA word address into a TCDM byte address, tracks outstanding reads with a
// credit scheme and buffers responses in a per-port FIFO.
// Ports:
//   clk_i, rst_i          : clock, synchronous active-high reset
//   base_addr_i           : TCDM byte base of the CGRA data window
//   waddr_*/wdata_*       : CGRA write address / write data channels
//   raddr_*               : CGRA read address channel
//   rdata_*               : CGRA read data channel
//   tcdm_q_*              : TCDM request (valid/ready, write, addr, data, strb)
//   tcdm_p_*              : TCDM response (valid, data)
//   idle_o                : no outstanding read and no buffered response
// Optional feature, macro CGRA_BRIDGE_PERF_CNT_EN: adds perf_clr_i and the
// per-port 32-bit saturating counters rd_cnt_o, wr_cnt_o, stall_cnt_o.
// -----------------------------------------------------------------------------
module cgra_tcdm_bridge
  import cgra_bridge_pkg::*;
#(
  parameter int unsigned NumPorts      = 4,
  parameter int unsigned CgraAddrWidth = 6,
  parameter int unsigned TcdmAddrWidth = 48,
  parameter int unsigned DataWidth     = 64,
  parameter int unsigned PayloadWidth  = 16,
  parameter int unsigned RspDepth      = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [TcdmAddrWidth-1:0]   base_addr_i,

  input  logic                       waddr_en_i   [NumPorts],
  input  logic [CgraAddrWidth-1:0]   waddr_msg_i  [NumPorts],
  output logic                       waddr_rdy_o  [NumPorts],
  input  logic                       wdata_en_i   [NumPorts],
  input  logic [PayloadWidth+1:0]    wdata_msg_i  [NumPorts],
  output logic                       wdata_rdy_o  [NumPorts],
  input  logic                       raddr_en_i   [NumPorts],
  input  logic [CgraAddrWidth-1:0]   raddr_msg_i  [NumPorts],
  output logic                       raddr_rdy_o  [NumPorts],
  output logic                       rdata_en_o   [NumPorts],
  output logic [PayloadWidth+1:0]    rdata_msg_o  [NumPorts],
  input  logic                       rdata_rdy_i  [NumPorts],

  output logic                       tcdm_q_valid_o [NumPorts],
  input  logic                       tcdm_q_ready_i [NumPorts],
  output logic                       tcdm_q_write_o [NumPorts],
  output logic [TcdmAddrWidth-1:0]   tcdm_q_addr_o  [NumPorts],
  output logic [DataWidth-1:0]       tcdm_q_data_o  [NumPorts],
  output logic [DataWidth/8-1:0]     tcdm_q_strb_o  [NumPorts],
  input  logic                       tcdm_p_valid_i [NumPorts],
  input  logic [DataWidth-1:0]       tcdm_p_data_i  [NumPorts],

`ifdef CGRA_BRIDGE_PERF_CNT_EN
  input  logic                       perf_clr_i,
  output logic [31:0]                rd_cnt_o    [NumPorts],
  output logic [31:0]                wr_cnt_o    [NumPorts],
  output logic [31:0]                stall_cnt_o [NumPorts],
`endif

  output logic                       idle_o
);

  localparam int unsigned Shift = addr_shift(DataWidth);
  localparam int unsigned CntW  = $clog2(RspDepth) + 1;

`ifdef CGRA_BRIDGE_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction
`endif

  logic [NumPorts-1:0] w_port_idle;

  for (genvar p = 0; p < NumPorts; p++) begin : g_port
    logic                     w_wr_pend, w_rd_pend, w_credit, w_wr_pred;
    logic                     w_gnt_wr, w_gnt_rd, w_contested;
    logic                     w_wr_fire, w_rd_fire, w_rsp_accept, w_rsp_pop;
    logic                     w_q_valid, w_q_write, w_wr_rdy, w_rd_rdy;
    logic                     w_fifo_empty, w_unused;
    logic [TcdmAddrWidth-1:0] w_wr_addr, w_rd_addr, w_q_addr;
    logic [DataWidth-1:0]     w_q_data;
    logic [PayloadWidth-1:0]  w_head;
    logic [CntW-1:0]          w_fifo_cnt;
    logic [CntW-1:0]          r_outst;
    prio_e                    r_prio;

    assign w_wr_pend = waddr_en_i[p] & wdata_en_i[p];
    assign w_wr_pred = wdata_msg_i[p][1];

    // A read is only eligible while every possible response still has a FIFO
    // slot; a pop in this cycle does not return credit until the next one.
    assign w_credit  = (int'(r_outst) + int'(w_fifo_cnt)) < int'(RspDepth);
    assign w_rd_pend = raddr_en_i[p] & w_credit;

    assign w_contested = w_wr_pend & w_rd_pend;
    assign w_gnt_wr    = w_wr_pend & (~w_rd_pend | (r_prio == PRIO_WRITE));
    assign w_gnt_rd    = w_rd_pend & ~w_gnt_wr;

    assign w_wr_addr = base_addr_i + (TcdmAddrWidth'(waddr_msg_i[p]) << Shift);
    assign w_rd_addr = base_addr_i + (TcdmAddrWidth'(raddr_msg_i[p]) << Shift);

    // A predicated-off write is swallowed locally without a TCDM request.
    always_comb begin
      w_q_valid = 1'b0;
      w_q_write = 1'b0;
      w_q_addr  = w_rd_addr;
      w_q_data  = '0;
      w_wr_rdy  = 1'b0;
      w_rd_rdy  = 1'b0;
      if (!rst_i) begin
        if (w_gnt_wr) begin
          w_q_write = 1'b1;
          w_q_addr  = w_wr_addr;
          w_q_data  = DataWidth'(wdata_msg_i[p][PayloadWidth+1:2]);
          w_q_valid = w_wr_pred;
          w_wr_rdy  = w_wr_pred ? tcdm_q_ready_i[p] : 1'b1;
        end else if (w_gnt_rd) begin
          w_q_valid = 1'b1;
          w_rd_rdy  = tcdm_q_ready_i[p];
        end
      end
    end

    assign w_wr_fire    = w_gnt_wr & w_wr_rdy;
    assign w_rd_fire    = w_gnt_rd & w_rd_rdy;
    assign w_rsp_accept = tcdm_p_valid_i[p] & (r_outst != '0) & ~rst_i;
    assign w_rsp_pop    = ~w_fifo_empty & rdata_rdy_i[p] & ~rst_i;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_outst <= '0;
        r_prio  <= PRIO_WRITE;
      end else begin
        if (w_contested && (w_wr_fire || w_rd_fire))
          r_prio <= (r_prio == PRIO_WRITE) ? PRIO_READ : PRIO_WRITE;
        case ({w_rd_fire, w_rsp_accept})
          2'b10:   r_outst <= r_outst + CntW'(1);
          2'b01:   r_outst <= r_outst - CntW'(1);
          default: r_outst <= r_outst;
        endcase
      end
    end

    cgra_bridge_rsp_fifo #(
      .Depth (RspDepth),
      .Width (PayloadWidth)
    ) u_rsp_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (w_rsp_accept),
      .data_i  (tcdm_p_data_i[p][PayloadWidth-1:0]),
      .pop_i   (w_rsp_pop),
      .data_o  (w_head),
      .empty_o (w_fifo_empty),
      .count_o (w_fifo_cnt)
    );

    assign tcdm_q_valid_o[p] = w_q_valid;
    assign tcdm_q_write_o[p] = w_q_write;
    assign tcdm_q_addr_o[p]  = w_q_addr;
    assign tcdm_q_data_o[p]  = w_q_data;
    assign tcdm_q_strb_o[p]  = '1;
    assign waddr_rdy_o[p]    = w_wr_rdy;
    assign wdata_rdy_o[p]    = w_wr_rdy;
    assign raddr_rdy_o[p]    = w_rd_rdy;
    assign rdata_en_o[p]     = w_rsp_pop;
    assign rdata_msg_o[p]    = {w_head, 1'b1, 1'b0};
    assign w_port_idle[p]    = (r_outst == '0) & w_fifo_empty;

    // Bypass bit and upper response bits carry no meaning for this bridge.
    assign w_unused = ^{wdata_msg_i[p][0], tcdm_p_data_i[p]};

`ifdef CGRA_BRIDGE_PERF_CNT_EN
    logic [31:0] r_rd_cnt, r_wr_cnt, r_stall_cnt;

    always_ff @(posedge clk_i) begin
      if (rst_i || perf_clr_i) begin
        r_rd_cnt    <= '0;
        r_wr_cnt    <= '0;
        r_stall_cnt <= '0;
      end else begin
        r_rd_cnt    <= sat_inc(r_rd_cnt, w_rd_fire);
        r_wr_cnt    <= sat_inc(r_wr_cnt, w_wr_fire & w_q_valid);
        r_stall_cnt <= sat_inc(r_stall_cnt, w_q_valid & ~tcdm_q_ready_i[p]);
      end
    end

    assign rd_cnt_o[p]    = r_rd_cnt;
    assign wr_cnt_o[p]    = r_wr_cnt;
    assign stall_cnt_o[p] = r_stall_cnt;
`endif
  end

  assign idle_o = &w_port_idle;

endmodule

// File: tb/tb_cgra_tcdm_bridge.sv
module tb_cgra_tcdm_bridge;

  localparam int NP = 4;
  localparam int AW = 6;
  localparam int TW = 48;
  localparam int DW = 64;
  localparam int PW = 16;
  localparam int RD = 4;
  localparam int MW = PW + 2;

  logic clk;
  logic rst;
  logic [TW-1:0] base;

  logic          waddr_en [NP], wdata_en [NP], raddr_en [NP], rdata_rdy [NP];
  logic          q_ready [NP], p_valid [NP];
  logic [AW-1:0] waddr_msg [NP], raddr_msg [NP];
  logic [MW-1:0] wdata_msg [NP], rdata_msg [NP];
  logic          waddr_rdy [NP], wdata_rdy [NP], raddr_rdy [NP], rdata_en [NP];
  logic          q_valid [NP], q_write [NP];
  logic [TW-1:0] q_addr [NP];
  logic [DW-1:0] q_data [NP], p_data [NP];
  logic [DW/8-1:0] q_strb [NP];
  logic          idle;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int            m_outst [NP];
  bit            m_prio  [NP];
  logic [PW-1:0] m_q     [NP][$];

  typedef struct {
    logic [AW-1:0] a;
    logic [PW-1:0] pl;
    logic          pred;
    logic [TW-1:0] base;
    logic          qrdy;
    logic          exp_valid;
    logic          exp_wrdy;
    logic [TW-1:0] exp_addr;
  } wvec_t;

  wvec_t wv [7];

  cgra_tcdm_bridge #(
    .NumPorts(NP), .CgraAddrWidth(AW), .TcdmAddrWidth(TW),
    .DataWidth(DW), .PayloadWidth(PW), .RspDepth(RD)
  ) dut (
    .clk_i(clk), .rst_i(rst), .base_addr_i(base),
    .waddr_en_i(waddr_en), .waddr_msg_i(waddr_msg), .waddr_rdy_o(waddr_rdy),
    .wdata_en_i(wdata_en), .wdata_msg_i(wdata_msg), .wdata_rdy_o(wdata_rdy),
    .raddr_en_i(raddr_en), .raddr_msg_i(raddr_msg), .raddr_rdy_o(raddr_rdy),
    .rdata_en_o(rdata_en), .rdata_msg_o(rdata_msg), .rdata_rdy_i(rdata_rdy),
    .tcdm_q_valid_o(q_valid), .tcdm_q_ready_i(q_ready), .tcdm_q_write_o(q_write),
    .tcdm_q_addr_o(q_addr), .tcdm_q_data_o(q_data), .tcdm_q_strb_o(q_strb),
    .tcdm_p_valid_i(p_valid), .tcdm_p_data_i(p_data),
    .idle_o(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    for (int p = 0; p < NP; p++) begin
      waddr_en[p] = 1'b0; wdata_en[p] = 1'b0; raddr_en[p] = 1'b0;
      rdata_rdy[p] = 1'b0; q_ready[p] = 1'b0; p_valid[p] = 1'b0;
      waddr_msg[p] = '0; raddr_msg[p] = '0; wdata_msg[p] = '0; p_data[p] = '0;
    end
  endtask

  initial begin
    wv[0] = '{6'h05, 16'hBEEF, 1'b1, 48'h1000,           1'b1, 1'b1, 1'b1, 48'h1028};
    wv[1] = '{6'h05, 16'hBEEF, 1'b0, 48'h1000,           1'b1, 1'b0, 1'b1, 48'h0};
    wv[2] = '{6'h3F, 16'h1234, 1'b1, 48'h0,              1'b1, 1'b1, 1'b1, 48'h1F8};
    wv[3] = '{6'h02, 16'hA5A5, 1'b1, 48'hFFFF_FFFF_FFF8, 1'b1, 1'b1, 1'b1, 48'h8};
    wv[4] = '{6'h00, 16'h0001, 1'b1, 48'h0,              1'b0, 1'b1, 1'b0, 48'h0};
    wv[5] = '{6'h10, 16'hFFFF, 1'b0, 48'h0,              1'b0, 1'b0, 1'b1, 48'h0};
    wv[6] = '{6'h21, 16'h0000, 1'b1, 48'h7000_0000_0000, 1'b1, 1'b1, 1'b1, 48'h7000_0000_0108};

    clear_inputs();
    base = 48'h1000;
    rst = 1'b1;
    next_cycle();
    // Requests pending during reset must not be acknowledged
    waddr_en[0] = 1'b1; wdata_en[0] = 1'b1; wdata_msg[0] = {16'h1111, 2'b10};
    raddr_en[0] = 1'b1; q_ready[0] = 1'b1; rdata_rdy[0] = 1'b1;
    mid();
    chk("rst waddr_rdy", waddr_rdy[0], 1'b0);
    chk("rst raddr_rdy", raddr_rdy[0], 1'b0);
    chk("rst q_valid", q_valid[0], 1'b0);
    chk("rst rdata_en", rdata_en[0], 1'b0);
    next_cycle();
    clear_inputs();
    rst = 1'b0;
    mid();
    chk("idle after reset", idle, 1'b1);
    next_cycle();

    // Table-driven write vectors on port 0
    for (int i = 0; i < 7; i++) begin
      base = wv[i].base;
      waddr_en[0] = 1'b1; wdata_en[0] = 1'b1; raddr_en[0] = 1'b0;
      waddr_msg[0] = wv[i].a;
      wdata_msg[0] = {wv[i].pl, wv[i].pred, 1'b0};
      q_ready[0] = wv[i].qrdy;
      mid();
      chk($sformatf("wvec%0d q_valid", i), q_valid[0], wv[i].exp_valid);
      chk($sformatf("wvec%0d waddr_rdy", i), waddr_rdy[0], wv[i].exp_wrdy);
      chk($sformatf("wvec%0d wdata_rdy", i), wdata_rdy[0], wv[i].exp_wrdy);
      chk($sformatf("wvec%0d raddr_rdy", i), raddr_rdy[0], 1'b0);
      if (wv[i].exp_valid) begin
        chk($sformatf("wvec%0d addr", i), q_addr[0], wv[i].exp_addr);
        chk($sformatf("wvec%0d data", i), q_data[0], 64'(wv[i].pl));
        chk($sformatf("wvec%0d strb", i), q_strb[0], 8'hFF);
        chk($sformatf("wvec%0d write", i), q_write[0], 1'b1);
      end
      next_cycle();
    end
    clear_inputs();
    base = 48'h1000;

    // Contested write/read alternates W,R,W,R
    waddr_en[1] = 1'b1; wdata_en[1] = 1'b1; waddr_msg[1] = 6'h01;
    wdata_msg[1] = {16'h5555, 2'b10};
    raddr_en[1] = 1'b1; raddr_msg[1] = 6'h02; q_ready[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      mid();
      chk($sformatf("arb%0d write", k), q_write[1], (k % 2 == 0));
      chk($sformatf("arb%0d valid", k), q_valid[1], 1'b1);
      chk($sformatf("arb%0d addr", k), q_addr[1], (k % 2 == 0) ? 48'h1008 : 48'h1010);
      next_cycle();
    end
    clear_inputs();
    // Two outstanding reads on port 1: responses come back one cycle later
    rdata_rdy[1] = 1'b1;
    p_valid[1] = 1'b1; p_data[1] = {$urandom, 16'h0, 16'h0011};
    mid();
    chk("arb rsp latency", rdata_en[1], 1'b0);
    next_cycle();
    p_data[1] = {$urandom, 16'h0, 16'h0022};
    mid();
    chk("arb rsp0 en", rdata_en[1], 1'b1);
    chk("arb rsp0 msg", rdata_msg[1], {16'h0011, 2'b10});
    next_cycle();
    p_valid[1] = 1'b0;
    mid();
    chk("arb rsp1 msg", rdata_msg[1], {16'h0022, 2'b10});
    next_cycle();
    mid();
    chk("arb idle", idle, 1'b1);
    chk("arb drained", rdata_en[1], 1'b0);
    next_cycle();

    // Credit limit on port 2
    raddr_en[2] = 1'b1; raddr_msg[2] = 6'h07; q_ready[2] = 1'b1; rdata_rdy[2] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mid();
      chk($sformatf("credit rd%0d rdy", k), raddr_rdy[2], 1'b1);
      chk($sformatf("credit rd%0d valid", k), q_valid[2], 1'b1);
      if (k == 0) begin
        chk("credit rd addr", q_addr[2], 48'h1038);
        chk("credit rd write", q_write[2], 1'b0);
      end
      next_cycle();
    end
    mid();
    chk("credit 5th rdy", raddr_rdy[2], 1'b0);
    chk("credit 5th valid", q_valid[2], 1'b0);
    next_cycle();
    for (int k = 0; k < 4; k++) begin
      p_valid[2] = 1'b1; p_data[2] = {$urandom, 16'hFFFF, 16'(16'h0A00 + k)};
      mid();
      chk($sformatf("credit fill%0d rdy", k), raddr_rdy[2], 1'b0);
      next_cycle();
    end
    p_valid[2] = 1'b0;
    mid();
    chk("credit full rdy", raddr_rdy[2], 1'b0);
    chk("credit full held", rdata_en[2], 1'b0);
    next_cycle();
    rdata_rdy[2] = 1'b1;
    mid();
    chk("credit pop0 en", rdata_en[2], 1'b1);
    chk("credit pop0 msg", rdata_msg[2], {16'h0A00, 2'b10});
    chk("credit rdy in pop", raddr_rdy[2], 1'b0);
    next_cycle();
    mid();
    chk("credit rdy after pop", raddr_rdy[2], 1'b1);
    chk("credit pop1 msg", rdata_msg[2], {16'h0A01, 2'b10});
    next_cycle();
    raddr_en[2] = 1'b0;
    for (int k = 2; k < 4; k++) begin
      mid();
      chk($sformatf("credit pop%0d en", k), rdata_en[2], 1'b1);
      chk($sformatf("credit pop%0d msg", k), rdata_msg[2], {16'(16'h0A00 + k), 2'b10});
      next_cycle();
    end
    p_valid[2] = 1'b1; p_data[2] = 64'h0A04;
    mid();
    chk("credit empty", rdata_en[2], 1'b0);
    next_cycle();
    p_valid[2] = 1'b0;
    mid();
    chk("credit late en", rdata_en[2], 1'b1);
    chk("credit late msg", rdata_msg[2], {16'h0A04, 2'b10});
    next_cycle();
    mid();
    chk("credit idle", idle, 1'b1);
    next_cycle();
    clear_inputs();

    // Push and pop in the same cycle on port 3, order preserved
    raddr_en[3] = 1'b1; q_ready[3] = 1'b1;
    repeat (4) next_cycle();
    raddr_en[3] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      p_valid[3] = 1'b1; p_data[3] = {$urandom, 16'h0, 16'(16'hC000 + k)};
      next_cycle();
    end
    p_data[3] = {$urandom, 16'h0, 16'hC003};
    rdata_rdy[3] = 1'b1;
    mid();
    chk("pushpop en", rdata_en[3], 1'b1);
    chk("pushpop msg0", rdata_msg[3], {16'hC000, 2'b10});
    next_cycle();
    p_valid[3] = 1'b0;
    for (int k = 1; k < 4; k++) begin
      mid();
      chk($sformatf("pushpop en%0d", k), rdata_en[3], 1'b1);
      chk($sformatf("pushpop msg%0d", k), rdata_msg[3], {16'(16'hC000 + k), 2'b10});
      next_cycle();
    end
    mid();
    chk("pushpop drained", rdata_en[3], 1'b0);
    chk("pushpop idle", idle, 1'b1);
    next_cycle();
    clear_inputs();

    // Reset with outstanding reads; late responses ignored
    raddr_en[0] = 1'b1; q_ready[0] = 1'b1;
    next_cycle();
    next_cycle();
    raddr_en[0] = 1'b0;
    mid();
    chk("rst2 busy", idle, 1'b0);
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    rdata_rdy[0] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      p_valid[0] = 1'b1; p_data[0] = {$urandom, $urandom};
      mid();
      chk($sformatf("rst2 idle%0d", k), idle, 1'b1);
      chk($sformatf("rst2 rdata_en%0d", k), rdata_en[0], 1'b0);
      next_cycle();
    end
    p_valid[0] = 1'b0;
    mid();
    chk("rst2 rdata_en final", rdata_en[0], 1'b0);
    chk("rst2 idle final", idle, 1'b1);
    next_cycle();

    // Randomized traffic against the reference model
    clear_inputs();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    base = {16'($urandom), $urandom};
    for (int p = 0; p < NP; p++) begin
      m_outst[p] = 0;
      m_prio[p]  = 1'b0;
      m_q[p].delete();
    end
    for (int c = 0; c < 400; c++) begin
      bit e_idle;
      for (int p = 0; p < NP; p++) begin
        waddr_en[p]  = 1'($urandom_range(0, 1));
        wdata_en[p]  = ($urandom_range(0, 3) != 0);
        waddr_msg[p] = 6'($urandom);
        wdata_msg[p] = 18'($urandom);
        raddr_en[p]  = ($urandom_range(0, 2) != 0);
        raddr_msg[p] = 6'($urandom);
        q_ready[p]   = ($urandom_range(0, 3) != 0);
        p_valid[p]   = 1'($urandom_range(0, 1));
        p_data[p]    = {$urandom, $urandom};
        rdata_rdy[p] = 1'($urandom_range(0, 1));
      end
      mid();
      e_idle = 1'b1;
      for (int p = 0; p < NP; p++)
        if (m_outst[p] != 0 || m_q[p].size() != 0) e_idle = 1'b0;
      chk("rnd idle", idle, e_idle);
      for (int p = 0; p < NP; p++) begin
        bit wp, rp, gw, gr, pred, ev, ewr, erd, eren, acc;
        logic [TW-1:0] ea;
        wp   = waddr_en[p] && wdata_en[p];
        rp   = raddr_en[p] && ((m_outst[p] + m_q[p].size()) < RD);
        gw   = wp && (!rp || !m_prio[p]);
        gr   = rp && !gw;
        pred = wdata_msg[p][1];
        ev   = gw ? pred : gr;
        ewr  = gw && (pred ? q_ready[p] : 1'b1);
        erd  = gr && q_ready[p];
        eren = (m_q[p].size() > 0) && rdata_rdy[p];
        ea   = gw ? base + 48'(waddr_msg[p]) * 48'd8 : base + 48'(raddr_msg[p]) * 48'd8;
        chk($sformatf("rnd p%0d q_valid", p), q_valid[p], ev);
        chk($sformatf("rnd p%0d waddr_rdy", p), waddr_rdy[p], ewr);
        chk($sformatf("rnd p%0d wdata_rdy", p), wdata_rdy[p], ewr);
        chk($sformatf("rnd p%0d raddr_rdy", p), raddr_rdy[p], erd);
        if (ev) begin
          chk($sformatf("rnd p%0d write", p), q_write[p], gw);
          chk($sformatf("rnd p%0d addr", p), q_addr[p], ea);
          if (gw) chk($sformatf("rnd p%0d data", p), q_data[p], 64'(wdata_msg[p][MW-1:2]));
        end
        chk($sformatf("rnd p%0d rdata_en", p), rdata_en[p], eren);
        if (eren) chk($sformatf("rnd p%0d rdata_msg", p), rdata_msg[p], {m_q[p][0], 2'b10});
        // advance model to the next clock edge
        acc = p_valid[p] && (m_outst[p] > 0);
        if (wp && rp && (ewr || erd)) m_prio[p] = !m_prio[p];
        if (eren) void'(m_q[p].pop_front());
        if (acc) m_q[p].push_back(p_data[p][PW-1:0]);
        m_outst[p] = m_outst[p] + (erd ? 1 : 0) - (acc ? 1 : 0);
      end
      next_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
